// File: rtl/mdsa_stream_adapter.sv
// Host-side initiator for the MDSA sorter: fills the sorter load register from a stream,
// launches the controller, captures the sorted matrix and drains it on an output stream.
module mdsa_stream_adapter #(
    parameter int DATA_W  = 8,
    parameter int N_ELEM  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     start,
    input  logic                     ctrl_ready,
    input  logic                     ctrl_oe,
    output logic                     load_en,
    output logic [N_ELEM*DATA_W-1:0] load_data,
    input  logic [N_ELEM*DATA_W-1:0] sorted_data,
    output logic                     busy,
    output logic                     error
);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_FILL, S_LAUNCH, S_ACK, S_RUN, S_DRAIN, S_ERR} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]  ld_reg   [N_ELEM];
    logic [DATA_W-1:0]  obuf_reg [N_ELEM];
    logic [DATA_W-1:0]  m_data_reg, m_data_next;
    logic               s_ready_reg, s_ready_next;
    logic               m_valid_reg, m_valid_next;
    logic               m_last_reg, m_last_next;
    logic               error_reg, error_next;
    logic               busy_reg, busy_next;
    logic               fill_we;
    logic               capture;
    logic               start_comb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FILL;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            m_data_reg  <= '0;
            s_ready_reg <= 1'b1;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            error_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            m_data_reg  <= m_data_next;
            s_ready_reg <= s_ready_next;
            m_valid_reg <= m_valid_next;
            m_last_reg  <= m_last_next;
            error_reg   <= error_next;
            busy_reg    <= busy_next;
        end
    end

    // Load slots keep the previous job's values until refilled; the output buffer is
    // loaded in one shot when the controller signals output_enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ELEM; i++) begin
            if (rst) begin
                ld_reg[i]   <= '0;
                obuf_reg[i] <= '0;
            end else begin
                if (fill_we && idx_reg == IDX_W'(i)) ld_reg[i] <= s_data;
                if (capture) obuf_reg[i] <= sorted_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        fill_we    = 1'b0;
        capture    = 1'b0;
        start_comb = 1'b0;
        case (state_reg)
            S_FILL: begin
                if (s_valid && s_ready_reg) begin
                    fill_we = 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = S_LAUNCH;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                if (ctrl_ready) begin
                    start_comb = 1'b1;
                    state_next = S_ACK;
                    cnt_next   = '0;
                end
            end
            S_ACK, S_RUN: begin
                // A done pulse wins over a timeout landing in the same cycle.
                if (ctrl_oe) begin
                    capture    = 1'b1;
                    state_next = S_DRAIN;
                    idx_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_ERR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (state_reg == S_ACK && !ctrl_ready) state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (m_valid_reg && m_ready) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = S_FILL;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        s_ready_next = (state_next == S_FILL);
        m_valid_next = (state_next == S_DRAIN);
        m_last_next  = (state_next == S_DRAIN) && (idx_next == IDX_LAST);
        error_next   = error_reg || (state_next == S_ERR);
        busy_next    = !((state_next == S_FILL) && (idx_next == '0));
        m_data_next  = m_data_reg;
        if (capture) m_data_next = sorted_data[DATA_W-1:0];
        else if (state_next == S_DRAIN) m_data_next = obuf_reg[idx_next];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_load
            assign load_data[gi*DATA_W +: DATA_W] = ld_reg[gi];
        end
    endgenerate

    assign s_ready = s_ready_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_last  = m_last_reg;
    assign error   = error_reg;
    assign busy    = busy_reg;
    assign start   = start_comb;
    assign load_en = start_comb;

endmodule

// File: tb/tb_mdsa_stream_adapter.sv
// Bench for mdsa_stream_adapter: a behavioural sort controller, an input-order scoreboard
// of sorted values, and a per-cycle compare process for the output stream.
module tb_mdsa_stream_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_last;
    logic         m_ready;
    logic         start;
    logic         ctrl_ready;
    logic         ctrl_oe;
    logic         load_en;
    logic [127:0] load_data;
    logic [127:0] sorted_data;
    logic         busy;
    logic         error;

    mdsa_stream_adapter #(.DATA_W(8), .N_ELEM(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .start(start), .ctrl_ready(ctrl_ready), .ctrl_oe(ctrl_oe),
        .load_en(load_en), .load_data(load_data), .sorted_data(sorted_data),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic sort16(input logic [7:0] a[16], output logic [7:0] b[16]);
        logic [7:0] t;
        b = a;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15 - i; j++)
                if (b[j] > b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
    endtask

    // Behavioural sort controller
    bit         cr_hold = 0, oe_never = 0, spurious_oe = 0;
    bit         ctl_busy = 0, ctl_real_oe = 0;
    int         oe_delay = 2, ctl_wait = 0;
    logic [7:0] ctl_raw [16];
    logic [7:0] ctl_vals [16];

    initial begin
        ctrl_ready = 1'b1; ctrl_oe = 1'b0; sorted_data = '0;
        forever begin
            @(negedge clk);
            if (rst) ctl_busy = 0;
            else if (start && load_en) begin
                for (int i = 0; i < 16; i++) ctl_raw[i] = load_data[i*8 +: 8];
                sort16(ctl_raw, ctl_vals);
                ctl_busy = 1; ctl_wait = 0;
            end
            @(posedge clk); #1;
            ctrl_oe = 1'b0; ctl_real_oe = 0;
            if (ctl_busy) begin
                ctrl_ready = 1'b0;
                if (!oe_never && ctl_wait >= oe_delay) begin
                    ctrl_oe = 1'b1; ctl_real_oe = 1;
                    for (int i = 0; i < 16; i++) sorted_data[i*8 +: 8] = ctl_vals[i];
                    ctl_busy = 0;
                end else ctl_wait++;
            end else begin
                ctrl_ready = !cr_hold;
                if (spurious_oe) begin
                    ctrl_oe = 1'b1;
                    sorted_data = {16{8'h5A}};
                end
            end
        end
    end

    bit bp_en = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: sorted copy of each job's accepted inputs
    logic [7:0] exp_q [$];
    bit         feeding = 0;
    bit         stall_prev = 0, expect_mv = 0;
    logic [7:0] stall_data;
    logic       stall_last;

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            exp_q.delete(); stall_prev = 0; expect_mv = 0;
        end else begin
            if (expect_mv) chk("oe_to_m_valid", m_valid, 1);
            expect_mv = ctrl_oe && ctl_real_oe;
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
                chk("stall_last", m_last, stall_last);
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) fail("unexpected_output");
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e);
                    chk("m_last", m_last, exp_q.size() == 0);
                    xfer_cnt++;
                    $display("xfer %0d data=%02h last=%0b", xfer_cnt, m_data, m_last);
                end
            end
            if (s_ready) chk("no_overlap", m_valid, 0);
            if (error) begin
                chk("err_s_ready", s_ready, 0);
                chk("err_m_valid", m_valid, 0);
            end
            chk("load_en_with_start", load_en, start);
            if (start) chk("start_needs_ready", ctrl_ready, 1);
            if (s_valid && s_ready && !feeding) fail("unexpected_accept");
        end
    end

    logic [7:0] job_in [16];

    task automatic feed_job();
        int k = 0, budget = 0;
        logic [7:0] srt [16];
        feeding = 1;
        while (k < 16 && budget < 100) begin
            @(posedge clk); #1;
            s_valid = 1'b1; s_data = job_in[k];
            @(negedge clk); budget++;
            if (s_ready) k++;
        end
        if (k < 16) fail("feed_bound");
        @(posedge clk); #1;
        s_valid = 1'b0; feeding = 0;
        sort16(job_in, srt);
        for (int i = 0; i < 16; i++) exp_q.push_back(srt[i]);
    endtask

    task automatic wait_drain(input string tag, input int base);
        int b = 0;
        while (exp_q.size() != 0 && b < 600) begin @(negedge clk); b++; end
        if (exp_q.size() != 0) fail({tag, "_drain_bound"});
        @(negedge clk);
        chk({tag, "_idle_s_ready"}, s_ready, 1);
        chk({tag, "_idle_m_valid"}, m_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_xfers"}, xfer_cnt - base, 16);
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_load_en"}, load_en, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_m_data"}, m_data, 0);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c, n, b, rdy_cyc, st_cyc, pulses;
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        apply_reset("rst0");

        // Job 1: 15..0 descending, immediate controller
        for (int i = 0; i < 16; i++) job_in[i] = 8'(15 - i);
        base = xfer_cnt;
        feed_job();
        chk("t1_model_first", exp_q[0], 8'd0);
        chk("t1_model_last", exp_q[15], 8'd15);
        @(negedge clk);
        chk("t1_start_latency", start, 1);
        chk("t1_s_ready_low", s_ready, 0);
        chk("t1_busy", busy, 1);
        chk("t1_load_slot0", load_data[7:0], 8'd15);
        chk("t1_load_slot15", load_data[127:120], 8'd0);
        wait_drain("t1", base);

        // Job 2: ctrl_ready held low for 5 cycles after fill completes
        for (int i = 0; i < 16; i++) job_in[i] = 8'(i * 7 + 3);
        @(negedge clk); cr_hold = 1;
        base = xfer_cnt;
        feed_job();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_start", start, 0);
            chk("t2_hold_busy", busy, 1);
            if (i == 4) cr_hold = 0;
        end
        rdy_cyc = -1; st_cyc = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ctrl_ready && rdy_cyc < 0) rdy_cyc = i;
            if (start) begin pulses++; if (st_cyc < 0) st_cyc = i; end
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_start_cycle", st_cyc, rdy_cyc);
        chk("t2_start_first", st_cyc, 0);
        wait_drain("t2", base);

        // Job 3: random data, ctrl_oe while still in ACK, 50% backpressure
        for (int i = 0; i < 16; i++) job_in[i] = 8'($urandom_range(0, 255));
        oe_delay = 0;
        @(negedge clk); bp_en = 1;
        base = xfer_cnt;
        feed_job();
        wait_drain("t3", base);
        @(negedge clk); bp_en = 0; oe_delay = 2;

        // Job 4: controller never finishes -> timeout error
        for (int i = 0; i < 16; i++) job_in[i] = 8'(i * 3);
        oe_never = 1;
        feed_job();
        @(negedge clk);
        chk("t4_start", start, 1);
        c = 0;
        while (!error && c < 600) begin @(negedge clk); c++; end
        chk("t4_timeout_cycles", c, 256);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_err_sticky", error, 1);
            chk("t4_err_s_ready", s_ready, 0);
            chk("t4_err_m_valid", m_valid, 0);
            chk("t4_err_busy", busy, 1);
        end
        oe_never = 0;
        apply_reset("t4_rst");
        for (int i = 0; i < 16; i++) job_in[i] = 8'($urandom_range(0, 255));
        base = xfer_cnt;
        feed_job();
        wait_drain("t4_after", base);

        // Job 5: reset after 7 output transfers
        for (int i = 0; i < 16; i++) job_in[i] = 8'(200 - i * 5);
        base = xfer_cnt;
        feed_job();
        n = 0; b = 0;
        while (n < 7 && b < 400) begin
            @(negedge clk); b++;
            if (m_valid && m_ready) n++;
        end
        if (n < 7) fail("t5_wait_bound");
        apply_reset("t5_rst");
        chk("t5_xfers_before_rst", xfer_cnt - base, 7);
        for (int i = 0; i < 16; i++) job_in[i] = 8'(i[3:0] ^ 4'hA);
        base = xfer_cnt;
        feed_job();
        wait_drain("t5_after", base);

        // Job 6: s_valid held during RUN, then spurious ctrl_oe in FILL
        for (int i = 0; i < 16; i++) job_in[i] = 8'($urandom_range(0, 255));
        oe_delay = 10;
        base = xfer_cnt;
        feed_job();
        @(posedge clk); #1; s_valid = 1'b1; s_data = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_s_ready_low", s_ready, 0);
            chk("t6_busy", busy, 1);
        end
        @(posedge clk); #1; s_valid = 1'b0;
        wait_drain("t6", base);
        oe_delay = 2;
        @(negedge clk); spurious_oe = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_spur_m_valid", m_valid, 0);
            chk("t6_spur_busy", busy, 0);
            chk("t6_spur_s_ready", s_ready, 1);
        end
        spurious_oe = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) job_in[i] = 8'(i * 11);
        base = xfer_cnt;
        feed_job();
        wait_drain("t6_after", base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
